// File: rtl/npu_intranet_mover_if.sv
// Bundle of controller-facing and buffer-facing signals of the out2act mover.
// The mover is the slave; the controller/buffer side is the master.
interface npu_intranet_mover_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ARRAY_M    = 4,
  parameter int ARRAY_N    = 4,
  parameter int LEN_WIDTH  = 16
);
  localparam int MW = $clog2(ARRAY_M);

  logic                  intranet_on_i;
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] o_base_addr_i;
  logic [ADDR_WIDTH-1:0] a_base_addr_i;
  logic [LEN_WIDTH-1:0]  len_i;
  logic                  relu_en_i;
  logic                  o_rd_en_o;
  logic [MW-1:0]         o_ram_idx_o;
  logic [ADDR_WIDTH-1:0] o_rd_addr_o;
  logic [31:0]           o_rd_data_i;
  logic [31:0]           a_ram_w_data_o;
  logic [ADDR_WIDTH-1:0] a_ram_w_addr_o;
  logic [ARRAY_N-1:0]    a_ram_w_en_o;
  logic                  busy_o;
  logic                  end_o;

  modport slave (
    input  intranet_on_i, start_i, o_base_addr_i, a_base_addr_i, len_i, relu_en_i, o_rd_data_i,
    output o_rd_en_o, o_ram_idx_o, o_rd_addr_o, a_ram_w_data_o, a_ram_w_addr_o, a_ram_w_en_o,
           busy_o, end_o
  );

  modport master (
    output intranet_on_i, start_i, o_base_addr_i, a_base_addr_i, len_i, relu_en_i, o_rd_data_i,
    input  o_rd_en_o, o_ram_idx_o, o_rd_addr_o, a_ram_w_data_o, a_ram_w_addr_o, a_ram_w_en_o,
           busy_o, end_o
  );
endinterface

// File: rtl/npu_intranet_mover.sv
// out2act mover: streams len words from the O_BUF banks into the A_BUF banks,
// one read per cycle, with a two-stage read-to-write pipeline and optional ReLU.
module npu_intranet_mover #(
  parameter int ADDR_WIDTH = 32,
  parameter int ARRAY_M    = 4,
  parameter int ARRAY_N    = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  npu_intranet_mover_if.slave   bus
);
  localparam int MB = $clog2(ARRAY_M);
  localparam int NB = $clog2(ARRAY_N);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] o_base_q, a_base_q;
  logic [LEN_WIDTH-1:0]  len_q, j_q;
  logic                  relu_q;
  logic                  rd_en_q;
  logic [MB-1:0]         rd_idx_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [LEN_WIDTH-1:0]  rd_j_q;
  logic                  p1_valid_q;
  logic [LEN_WIDTH-1:0]  p1_j_q;
  logic [ARRAY_N-1:0]    w_en_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [31:0]           w_data_q;
  logic                  busy_q, end_q;

  logic                  accept_s, abort_s, issue_s, busy_d, end_d;
  logic [LEN_WIDTH-1:0]  rd_j_s;
  logic [ADDR_WIDTH-1:0] rd_base_s;

  function automatic logic [31:0] relu32(input logic [31:0] w, input logic en);
    logic [31:0] r;
    r = w;
    for (int k = 0; k < 4; k++) begin
      if (en && w[8*k+7]) begin
        r[8*k +: 8] = 8'h00;
      end else begin
        r[8*k +: 8] = w[8*k +: 8];
      end
    end
    return r;
  endfunction

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state; DRAIN ends once the final write is on the bus and nothing is behind it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = (bus.len_i == '0) ? DONE : READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (abort_s) begin
          state_d = IDLE;
        end else if (j_q >= len_q) begin
          state_d = DRAIN;
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        if (abort_s) begin
          state_d = IDLE;
        end else if (!p1_valid_q && (w_en_q != '0)) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode: read issue selection and registered status next values
  always_comb begin
    accept_s  = (state_q == IDLE) && bus.start_i && bus.intranet_on_i;
    abort_s   = ((state_q == READ) || (state_q == DRAIN)) && !bus.intranet_on_i;
    issue_s   = 1'b0;
    rd_j_s    = '0;
    rd_base_s = o_base_q;
    if (accept_s) begin
      issue_s   = (bus.len_i != '0);
      rd_base_s = bus.o_base_addr_i;
    end else if (state_q == READ) begin
      issue_s = !abort_s && (j_q < len_q);
      rd_j_s  = j_q;
    end else begin
      issue_s = 1'b0;
    end
    busy_d = (state_d != IDLE);
    end_d  = (state_d == DONE);
  end

  // Latched fields, read stage, data-capture stage and write stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      o_base_q   <= '0;
      a_base_q   <= '0;
      len_q      <= '0;
      relu_q     <= 1'b0;
      j_q        <= '0;
      rd_en_q    <= 1'b0;
      rd_idx_q   <= '0;
      rd_addr_q  <= '0;
      rd_j_q     <= '0;
      p1_valid_q <= 1'b0;
      p1_j_q     <= '0;
      w_en_q     <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      busy_q <= busy_d;
      end_q  <= end_d;
      if (accept_s) begin
        o_base_q <= bus.o_base_addr_i;
        a_base_q <= bus.a_base_addr_i;
        len_q    <= bus.len_i;
        relu_q   <= bus.relu_en_i;
        j_q      <= (bus.len_i != '0) ? LEN_WIDTH'(1) : '0;
      end else if (issue_s) begin
        j_q <= j_q + LEN_WIDTH'(1);
      end else begin
        j_q <= j_q;
      end
      rd_en_q   <= issue_s;
      rd_idx_q  <= issue_s ? rd_j_s[MB-1:0] : '0;
      rd_addr_q <= issue_s ? (rd_base_s + ADDR_WIDTH'(rd_j_s >> MB)) : '0;
      rd_j_q    <= issue_s ? rd_j_s : '0;
      // Word index follows the read so the write bank/address line up with its data
      p1_valid_q <= rd_en_q && !abort_s;
      p1_j_q     <= rd_j_q;
      if (p1_valid_q && !abort_s) begin
        w_en_q   <= ARRAY_N'(1) << p1_j_q[NB-1:0];
        w_addr_q <= a_base_q + ADDR_WIDTH'(p1_j_q >> NB);
        w_data_q <= relu32(bus.o_rd_data_i, relu_q);
      end else begin
        w_en_q   <= '0;
        w_addr_q <= '0;
        w_data_q <= '0;
      end
    end
  end

  assign bus.o_rd_en_o      = rd_en_q;
  assign bus.o_ram_idx_o    = rd_idx_q;
  assign bus.o_rd_addr_o    = rd_addr_q;
  assign bus.a_ram_w_en_o   = w_en_q;
  assign bus.a_ram_w_addr_o = w_addr_q;
  assign bus.a_ram_w_data_o = w_data_q;
  assign bus.busy_o         = busy_q;
  assign bus.end_o          = end_q;
endmodule

// File: tb/tb_npu_intranet_mover.sv
// Bench for npu_intranet_mover: a per-cycle reference built from the transfer
// timeline (reads 1..len, writes 3..len+2, end at len+3) with an O_BUF responder.
module tb_npu_intranet_mover;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  npu_intranet_mover_if intf ();
  npu_intranet_mover dut (.clk_i(clk), .rst_ni(rst_n), .bus(intf.slave));

  int checks = 0;
  int errors = 0;
  int mem_mode = 0;
  logic [31:0] mem_seed = 32'h0;
  logic [31:0] last_wdata;

  typedef struct {
    int          mode;
    logic [31:0] ob;
    logic [31:0] ab;
    int          len;
    bit          relu;
    int          abort_c;
    int          start2_c;
    int          exp_end_cyc;
    int          exp_writes;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [1:0] bank, input logic [31:0] addr);
    case (mem_mode)
      0:       mem_word = {14'h0, bank, addr[15:0]};
      1:       mem_word = mem_seed ^ ({30'h0, bank} * 32'h9E3779B1) ^ (addr * 32'h85EBCA6B);
      default: mem_word = 32'h80FF7F01;
    endcase
  endfunction

  function automatic logic [31:0] relu_ref(input logic [31:0] w, input bit en);
    logic [31:0] r;
    r = w;
    for (int k = 0; k < 4; k++) begin
      byte lane;
      lane = byte'(w[8*k +: 8]);
      if (en && lane < 0) r[8*k +: 8] = 8'h00;
    end
    return r;
  endfunction

  // O_BUF model: data for the read presented in one cycle appears in the next
  always @(posedge clk)
    intf.o_rd_data_i <= intf.o_rd_en_o ? mem_word(intf.o_ram_idx_o, intf.o_rd_addr_o) : $urandom;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 64'(intf.o_rd_en_o), 64'h0);
    chk({tag, "_rd_idx"}, 64'(intf.o_ram_idx_o), 64'h0);
    chk({tag, "_rd_addr"}, 64'(intf.o_rd_addr_o), 64'h0);
    chk({tag, "_w_en"}, 64'(intf.a_ram_w_en_o), 64'h0);
    chk({tag, "_w_addr"}, 64'(intf.a_ram_w_addr_o), 64'h0);
    chk({tag, "_w_data"}, 64'(intf.a_ram_w_data_o), 64'h0);
    chk({tag, "_busy"}, 64'(intf.busy_o), 64'h0);
    chk({tag, "_end"}, 64'(intf.end_o), 64'h0);
  endtask

  task automatic run_xfer(input vec_t v);
    int end_cyc = 0, nw = 0, nend = 0, j, done_c;
    bit live, rd_exp, wr_exp;
    logic [31:0] ea, ed;
    mem_mode = v.mode;
    mem_seed = $urandom;
    done_c   = (v.len == 0) ? 1 : v.len + 3;
    @(negedge clk);
    intf.intranet_on_i = 1'b1;
    intf.start_i       = 1'b1;
    intf.o_base_addr_i = v.ob;
    intf.a_base_addr_i = v.ab;
    intf.len_i         = 16'(v.len);
    intf.relu_en_i     = v.relu;
    @(posedge clk);
    for (int c = 1; c <= v.len + 6; c++) begin
      @(negedge clk);
      intf.start_i = (v.start2_c != 0) && (c == v.start2_c);
      if (intf.start_i) begin
        intf.o_base_addr_i = v.ob + 32'h100;
        intf.a_base_addr_i = v.ab ^ 32'hFFFF;
        intf.len_i         = 16'd3;
      end
      if (v.abort_c != 0 && c == v.abort_c) intf.intranet_on_i = 1'b0;
      live   = (v.abort_c == 0) || (c <= v.abort_c);
      rd_exp = live && (c <= v.len);
      wr_exp = live && (c >= 3) && (c <= v.len + 2);
      chk("rd_en", 64'(intf.o_rd_en_o), 64'(rd_exp));
      if (rd_exp) begin
        j  = c - 1;
        ea = v.ob + 32'(j / 4);
        chk("rd_idx", 64'(intf.o_ram_idx_o), 64'(j % 4));
        chk("rd_addr", 64'(intf.o_rd_addr_o), 64'(ea));
      end
      chk("w_en", 64'(intf.a_ram_w_en_o), wr_exp ? (64'h1 << ((c - 3) % 4)) : 64'h0);
      if (wr_exp) begin
        j  = c - 3;
        ea = v.ab + 32'(j / 4);
        ed = relu_ref(mem_word(2'(j % 4), v.ob + 32'(j / 4)), v.relu);
        chk("w_addr", 64'(intf.a_ram_w_addr_o), 64'(ea));
        chk("w_data", 64'(intf.a_ram_w_data_o), 64'(ed));
        last_wdata = intf.a_ram_w_data_o;
      end
      chk("busy", 64'(intf.busy_o), 64'(live && (c <= done_c)));
      chk("end", 64'(intf.end_o), 64'((v.abort_c == 0) && (c == done_c)));
      if (intf.end_o) begin
        end_cyc = c;
        nend++;
      end
      if (intf.a_ram_w_en_o != 4'b0000) nw++;
    end
    intf.start_i       = 1'b0;
    intf.intranet_on_i = 1'b1;
    chk("end_cycle", 64'(end_cyc), 64'(v.exp_end_cyc));
    chk("end_count", 64'(nend), 64'(v.exp_end_cyc != 0));
    chk("write_count", 64'(nw), 64'(v.exp_writes));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t rv;
    //          mode ob            ab            len relu abort s2  end wr
    tbl[0] = '{0, 32'h10,       32'h20,       8,  1'b0, 0, 0,  11, 8};
    tbl[1] = '{1, 32'h55,       32'h66,       0,  1'b0, 0, 0,  1,  0};
    tbl[2] = '{1, 32'h1234,     32'h4321,     1,  1'b1, 0, 0,  4,  1};
    tbl[3] = '{0, 32'h10,       32'h20,       8,  1'b0, 0, 4,  11, 8};
    tbl[4] = '{0, 32'h10,       32'h20,       8,  1'b0, 5, 0,  0,  3};
    tbl[5] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFE, 9,  1'b1, 0, 0,  12, 9};
    tbl[6] = '{1, 32'h300,      32'h400,      5,  1'b1, 7, 0,  0,  5};
    tbl[7] = '{1, 32'h0,        32'h8,        3,  1'b0, 0, 6,  6,  3};

    intf.intranet_on_i = 1'b0;
    intf.start_i       = 1'b0;
    intf.o_base_addr_i = 32'h0;
    intf.a_base_addr_i = 32'h0;
    intf.len_i         = 16'h0;
    intf.relu_en_i     = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_xfer(tbl[i]);

    // ReLU on a known word, then the same word without ReLU
    rv = '{2, 32'h0, 32'h0, 1, 1'b1, 0, 0, 4, 1};
    run_xfer(rv);
    chk("relu_on_word", 64'(last_wdata), 64'h00007F01);
    rv.relu = 1'b0;
    run_xfer(rv);
    chk("relu_off_word", 64'(last_wdata), 64'h80FF7F01);

    // start while the controller has the mover disabled
    @(negedge clk);
    intf.intranet_on_i = 1'b0;
    intf.start_i       = 1'b1;
    intf.len_i         = 16'd4;
    @(negedge clk);
    intf.start_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("off_busy", 64'(intf.busy_o), 64'h0);
      chk("off_end", 64'(intf.end_o), 64'h0);
      chk("off_rd_en", 64'(intf.o_rd_en_o), 64'h0);
      @(negedge clk);
    end
    intf.intranet_on_i = 1'b1;

    // reset in cycle 4 of a len=8 transfer, then a fresh len=2 transfer
    mem_mode           = 0;
    intf.start_i       = 1'b1;
    intf.o_base_addr_i = 32'h40;
    intf.a_base_addr_i = 32'h80;
    intf.len_i         = 16'd8;
    @(posedge clk);
    @(negedge clk);
    intf.start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_rd_en", 64'(intf.o_rd_en_o), 64'h1);
    chk("pre_reset_busy", 64'(intf.busy_o), 64'h1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    chk_all_zero("held_reset");
    rst_n = 1'b1;
    rv = '{0, 32'h40, 32'h80, 2, 1'b0, 0, 0, 5, 2};
    run_xfer(rv);

    // randomized transfers against the timeline model
    for (int i = 0; i < 12; i++) begin
      int lim;
      rv.mode     = 1;
      rv.ob       = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15))) : $urandom;
      rv.ab       = $urandom;
      rv.len      = $urandom_range(0, 20);
      rv.relu     = 1'($urandom_range(0, 1));
      rv.abort_c  = 0;
      rv.start2_c = 0;
      if (rv.len > 0 && $urandom_range(0, 2) == 0) rv.abort_c = $urandom_range(1, rv.len + 2);
      else if (rv.len > 0 && $urandom_range(0, 1) == 0) rv.start2_c = $urandom_range(1, rv.len + 3);
      if (rv.abort_c != 0) begin
        lim            = (rv.len + 2 < rv.abort_c) ? rv.len + 2 : rv.abort_c;
        rv.exp_writes  = (lim > 2) ? lim - 2 : 0;
        rv.exp_end_cyc = 0;
      end else begin
        rv.exp_writes  = rv.len;
        rv.exp_end_cyc = (rv.len == 0) ? 1 : rv.len + 3;
      end
      run_xfer(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/npu_intranet_mover.md
Name: npu_intranet_mover

Overview:
- Executes the out2act instruction. It moves a block of 32-bit words from the output buffer banks (O_BUF) into the activation buffer banks (A_BUF), so the next layer can consume the previous layer's results.
- It sits between the NPU controller FSM and the two buffers.
- It is started by the controller's intranet start/base-address signals and returns a one-cycle end pulse when the move is complete.
- An optional per-byte ReLU is applied to each word in flight.

Parameters:
- ADDR_WIDTH, 32, width of buffer word addresses.
- ARRAY_M, 4, number of O_BUF banks; must be a power of two, at least 2.
- ARRAY_N, 4, number of A_BUF banks; must be a power of two, at least 2.
- LEN_WIDTH, 16, width of the transfer length field.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- intranet_on_i  in  1  enable level from controller; deassertion aborts.
- start_i  in  1  single-cycle start pulse (Intra_sig_start).
- o_base_addr_i  in  ADDR_WIDTH  O_BUF base word address.
- a_base_addr_i  in  ADDR_WIDTH  A_BUF base word address.
- len_i  in  LEN_WIDTH  total number of words to move.
- relu_en_i  in  1  clamp negative int8 lanes to zero.
- o_rd_en_o  out  1  O_BUF read strobe.
- o_ram_idx_o  out  $clog2(ARRAY_M)  O_BUF bank select.
- o_rd_addr_o  out  ADDR_WIDTH  O_BUF read address.
- o_rd_data_i  in  32  O_BUF read data; valid exactly 1 cycle after o_rd_en_o.
- a_ram_w_data_o  out  32  A_BUF write data.
- a_ram_w_addr_o  out  ADDR_WIDTH  A_BUF write address.
- a_ram_w_en_o  out  ARRAY_N  one-hot A_BUF bank write enable.
- busy_o  out  1  high while not IDLE.
- end_o  out  1  single-cycle completion pulse (Intra_sig_end).

Behaviour:
- Reset: asynchronous on rst_ni low.
  - All outputs are 0, and the FSM is forced to IDLE.
  - Counters and latched fields clear.
  - Reset mid-transfer discards the transfer with no end_o.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start_i is accepted only when intranet_on_i is 1.
  - On acceptance, latch o_base, a_base, len and relu_en, and clear word index j.
  - If len_i is nonzero, go to READ. If len_i is 0, go to DONE.
  - start_i with intranet_on_i low is ignored.
- READ:
  - Issue one read per cycle for j = 0 .. len-1: o_rd_en_o=1, o_ram_idx_o = j mod ARRAY_M, o_rd_addr_o = o_base + j/ARRAY_M.
  - All read outputs are registered.
  - After issuing j = len-1, go to DRAIN.
- Write pipeline:
  - Read issued in cycle t; data sampled at t+1; write outputs registered and asserted in cycle t+2.
  - a_ram_w_en_o is one-hot at bit (j mod ARRAY_N).
  - a_ram_w_addr_o = a_base + j/ARRAY_N.
  - a_ram_w_data_o is the read data, processed by ReLU if enabled.
- DRAIN: wait until the last write has been presented, then go to DONE.
- DONE: end_o=1 for exactly one cycle, then go to IDLE.
- Latency: with start accepted at edge 0:
  - reads occur in cycles 1..len;
  - writes occur in cycles 3..len+2;
  - end_o is asserted in cycle len+3;
  - for len=0, end_o is asserted in cycle 1.
- ReLU: each byte lane [8k+7:8k] is treated as signed. If relu_en is latched and bit 8k+7 is 1, that lane becomes 0x00; otherwise it passes unchanged.
- Address arithmetic: modulo 2^ADDR_WIDTH; wrap-around is silent. The j/ARRAY_* divisions are shifts.
- start_i while busy: ignored; latched fields are not disturbed.
- Abort: intranet_on_i low in READ or DRAIN.
  - From the next cycle, no new reads are issued and in-flight writes are suppressed (a_ram_w_en_o=0).
  - The FSM returns to IDLE with no end_o.
- Any output enable is 0 whenever it is not strobing.
- busy_o=1 in READ, DRAIN and DONE.

Test Plan:
- Basic move: M=N=4, o_base=0x10, a_base=0x20, len=8, O bank b addr a holds {b, a}.
  - Reads: (bank0, 0x10), (1, 0x10), (2, 0x10), (3, 0x10), (0, 0x11) … (3, 0x11).
  - Writes: a_ram_w_en 0001, 0010, 0100, 1000 repeating; addresses 0x20 ×4 then 0x21 ×4; data matches.
  - end_o asserted in cycle 11.
- ReLU: relu_en=1, word 0x80FF7F01 → written as 0x00007F01. With relu_en=0 the word is written unchanged.
- Zero length: len=0 with intranet_on=1 → end_o in cycle 1; o_rd_en_o and a_ram_w_en_o stay 0.
- Ignored starts:
  - start with intranet_on=0 → busy_o stays 0, no end_o.
  - A second start at cycle 4 of a len=8 transfer with different bases → original addresses are unaffected; exactly one end_o.
- Abort: deassert intranet_on_i in cycle 5 of a len=8 transfer → no reads and no writes from cycle 6; FSM in IDLE; end_o never asserted.
- Reset mid-transfer: pull rst_ni low in cycle 4 → all outputs 0 immediately (asynchronously); after release a fresh len=2 transfer completes correctly.
